// File: rtl/uart_rom_loader_pkg.sv
// uart_rom_loader_pkg: shared state enums and frame constants for the UART ROM loader
package uart_rom_loader_pkg;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {LD_LEN0, LD_LEN1, LD_DATA, LD_DONE, LD_ERROR} ld_state_t;
  localparam int BITS_PER_FRAME = 10;
  function automatic int half_bit(input int wait_cycles);
    return wait_cycles / 2;
  endfunction
endpackage

// File: rtl/uart_rom_loader_if.sv
// uart_rom_loader_if: serial input plus ROM write port and loader status
interface uart_rom_loader_if #(parameter int ADDR_WIDTH = 8);
  logic uart_rx;
  logic rom_we;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [31:0] rom_wdata;
  logic cpu_hold;
  logic done;
  logic frame_err;
  logic overflow;
  modport master(input uart_rx, output rom_we, rom_addr, rom_wdata, cpu_hold, done, frame_err, overflow);
  modport slave(output uart_rx, input rom_we, rom_addr, rom_wdata, cpu_hold, done, frame_err, overflow);
endinterface

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: synchronised UART receiver emitting one-cycle byte and frame-error pulses
module uart_rx_byte
  import uart_rom_loader_pkg::*;
#(
  parameter int WAIT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_rx,
  output logic       o_valid,
  output logic [7:0] o_byte,
  output logic       o_ferr
);
  localparam int CW = $clog2(WAIT);
  rx_state_t r_state;
  logic [1:0] r_sync;
  logic r_prev;
  logic [CW-1:0] r_cnt;
  logic [2:0] r_bit;
  logic [7:0] r_shift;
  logic w_rx, w_half, w_full;
  assign w_rx = r_sync[1];
  assign w_half = r_cnt == CW'(half_bit(WAIT) - 1);
  assign w_full = r_cnt == CW'(WAIT - 1);
  assign o_byte = r_shift;
  always_ff @(posedge clk)
    if (!reset) begin
      r_state <= RX_IDLE;
      r_sync <= 2'b11;
      r_prev <= 1'b1;
      r_cnt <= '0;
      r_bit <= '0;
      r_shift <= '0;
      o_valid <= 1'b0;
      o_ferr <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_rx};
      r_prev <= w_rx;
      o_valid <= 1'b0;
      o_ferr <= 1'b0;
      r_cnt <= r_cnt + 1'b1;
      case (r_state)
        RX_IDLE: begin
          r_cnt <= '0;
          r_bit <= '0;
          if (r_prev && !w_rx) r_state <= RX_START;
        end
        RX_START: if (w_half) begin
          r_cnt <= '0;
          r_state <= w_rx ? RX_IDLE : RX_DATA;
        end
        RX_DATA: if (w_full) begin
          r_cnt <= '0;
          r_shift <= {w_rx, r_shift[7:1]};
          r_bit <= r_bit + 1'b1;
          if (r_bit == 3'(BITS_PER_FRAME - 3)) r_state <= RX_STOP;
        end
        RX_STOP: if (w_full) begin
          r_state <= RX_IDLE;
          o_valid <= w_rx;
          o_ferr <= !w_rx;
        end
      endcase
    end
endmodule

// File: rtl/uart_rom_loader.sv
// uart_rom_loader: loads a length-prefixed UART program image into ROM and releases the CPU when complete
module uart_rom_loader
  import uart_rom_loader_pkg::*;
#(
  parameter int WAIT = 8,
  parameter int ADDR_WIDTH = 8
) (
  input logic clk,
  input logic reset,
  uart_rom_loader_if.master bus
);
  ld_state_t r_state;
  logic [15:0] r_n, r_k;
  logic [1:0] r_bcnt;
  logic [23:0] r_word;
  logic r_we, r_hold, r_done, r_ferr, r_ovf;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0] r_wdata;
  logic w_valid, w_ferr, w_fits;
  logic [7:0] w_byte;
  logic [31:0] w_word;
  uart_rx_byte #(.WAIT(WAIT)) u_rx (
    .clk(clk),
    .reset(reset),
    .i_rx(bus.uart_rx),
    .o_valid(w_valid),
    .o_byte(w_byte),
    .o_ferr(w_ferr)
  );
  assign w_word = {w_byte, r_word};
  assign w_fits = (r_k >> ADDR_WIDTH) == 16'd0;
  assign bus.rom_we = r_we;
  assign bus.rom_addr = r_addr;
  assign bus.rom_wdata = r_wdata;
  assign bus.cpu_hold = r_hold;
  assign bus.done = r_done;
  assign bus.frame_err = r_ferr;
  assign bus.overflow = r_ovf;
  always_ff @(posedge clk)
    if (!reset) begin
      r_state <= LD_LEN0;
      r_n <= '0;
      r_k <= '0;
      r_bcnt <= '0;
      r_word <= '0;
      r_we <= 1'b0;
      r_addr <= '0;
      r_wdata <= '0;
      r_hold <= 1'b1;
      r_done <= 1'b0;
      r_ferr <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (w_ferr && r_state inside {LD_LEN0, LD_LEN1, LD_DATA}) begin
        r_ferr <= 1'b1;
        r_state <= LD_ERROR;
      end else if (w_valid)
        case (r_state)
          LD_LEN0: begin
            r_n[7:0] <= w_byte;
            r_state <= LD_LEN1;
          end
          LD_LEN1: begin
            r_n[15:8] <= w_byte;
            r_state <= {w_byte, r_n[7:0]} == 16'd0 ? LD_DONE : LD_DATA;
          end
          LD_DATA: begin
            r_word <= w_word[31:8];
            r_bcnt <= r_bcnt + 2'd1;
            if (r_bcnt == 2'd3) begin
              r_k <= r_k + 16'd1;
              if (w_fits) begin
                r_we <= 1'b1;
                r_addr <= r_k[ADDR_WIDTH-1:0];
                r_wdata <= w_word;
              end else r_ovf <= 1'b1;
              if (r_k == r_n - 16'd1) r_state <= LD_DONE;
            end
          end
          default: ;
        endcase
      if (r_state == LD_DONE) begin
        r_done <= 1'b1;
        r_hold <= 1'b0;
      end
    end
endmodule

// File: tb/tb_uart_rom_loader.sv
// tb_uart_rom_loader: randomized image loads on two ROM widths checked against an image-level model
module tb_uart_rom_loader;
  import uart_rom_loader_pkg::*;
  localparam int W = 8;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic rx = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [39:0] wa[$];
  logic [39:0] wb[$];
  bit pa, pb;
  uart_rom_loader_if #(.ADDR_WIDTH(8)) bus_a();
  uart_rom_loader_if #(.ADDR_WIDTH(2)) bus_b();
  assign bus_a.uart_rx = rx;
  assign bus_b.uart_rx = rx;
  uart_rom_loader #(.WAIT(W), .ADDR_WIDTH(8)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  uart_rom_loader #(.WAIT(W), .ADDR_WIDTH(2)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (bus_a.rom_we) begin
      chk("we_gap_a", 64'(pa), 64'd0);
      wa.push_back({bus_a.rom_addr, bus_a.rom_wdata});
    end
    if (bus_b.rom_we) begin
      chk("we_gap_b", 64'(pb), 64'd0);
      wb.push_back({6'd0, bus_b.rom_addr, bus_b.rom_wdata});
    end
    pa = bus_a.rom_we;
    pb = bus_b.rom_we;
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    rx = 1'b1;
    tick(3);
    reset = 1'b1;
    wa.delete();
    wb.delete();
  endtask
  task automatic check_reset(input string tag);
    chk({tag, "_a"}, {bus_a.rom_we, bus_a.rom_addr, bus_a.rom_wdata, bus_a.cpu_hold, bus_a.done, bus_a.frame_err, bus_a.overflow}, {1'b0, 8'd0, 32'd0, 1'b1, 3'd0});
    chk({tag, "_b"}, {bus_b.rom_we, bus_b.rom_addr, bus_b.rom_wdata, bus_b.cpu_hold, bus_b.done, bus_b.frame_err, bus_b.overflow}, {1'b0, 2'd0, 32'd0, 1'b1, 3'd0});
  endtask
  task automatic send_byte(input logic [7:0] b, input bit bad);
    logic [9:0] f;
    f = {~bad, b, 1'b0};
    for (int i = 0; i < BITS_PER_FRAME; i++) begin
      rx = f[i];
      tick(W);
    end
    rx = 1'b1;
  endtask
  task automatic send_image(input logic [7:0] q[$], input int bad);
    for (int i = 0; i < q.size(); i++) begin
      send_byte(q[i], i == bad);
      tick($urandom_range(0, 4));
    end
  endtask
  task automatic model(input logic [7:0] q[$], input int bad, input int aw, output logic [39:0] e[$], output bit done, output bit ferr, output bit ovf);
    int lim, n, cw;
    e = {};
    ovf = 1'b0;
    lim = (bad >= 0 && bad < q.size()) ? bad : q.size();
    n = lim >= 2 ? int'({q[1], q[0]}) : 0;
    cw = lim >= 2 ? ((lim - 2) / 4 < n ? (lim - 2) / 4 : n) : 0;
    for (int w = 0; w < cw; w++)
      if (w < (1 << aw)) e.push_back({8'(w), q[2 + 4 * w + 3], q[2 + 4 * w + 2], q[2 + 4 * w + 1], q[2 + 4 * w]});
      else ovf = 1'b1;
    done = lim >= 2 && lim >= 2 + 4 * n;
    ferr = !done && bad >= 0 && bad < q.size();
  endtask
  task automatic cmp(input string tag, input logic [39:0] got[$], input logic [39:0] exp[$], input logic [3:0] flags, input logic [3:0] eflags);
    chk({tag, "_nwr"}, 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < got.size() && i < exp.size(); i++) chk({tag, "_wr"}, 64'(got[i]), 64'(exp[i]));
    chk({tag, "_flags"}, 64'(flags), 64'(eflags));
  endtask
  task automatic verify(input string tag, input logic [7:0] q[$], input int bad);
    logic [39:0] e[$];
    bit d, f, o;
    tick(20);
    model(q, bad, 8, e, d, f, o);
    cmp({tag, "_a"}, wa, e, {bus_a.done, bus_a.cpu_hold, bus_a.frame_err, bus_a.overflow}, {d, !d, f, o});
    model(q, bad, 2, e, d, f, o);
    cmp({tag, "_b"}, wb, e, {bus_b.done, bus_b.cpu_hold, bus_b.frame_err, bus_b.overflow}, {d, !d, f, o});
  endtask
  initial begin
    logic [7:0] q[$];
    int t, n, bad;
    do_reset();
    check_reset("reset");
    q = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    foreach (q[i]) send_byte(q[i], 1'b0);
    t = 0;
    while (!bus_a.rom_we && t < 40) begin
      tick(1);
      t++;
    end
    chk("one_word_we", 64'(bus_a.rom_we), 64'd1);
    chk("one_word_wdata", 64'(bus_a.rom_wdata), 64'h12345678);
    chk("one_word_done_at_we", {bus_a.done, bus_a.cpu_hold}, 2'b01);
    tick(1);
    chk("one_word_done_next", {bus_a.done, bus_a.cpu_hold}, 2'b10);
    verify("one_word", q, -1);
    do_reset();
    q = '{8'h02, 8'h00, 8'h10, 8'h00, 8'h10, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h00};
    send_image(q, -1);
    verify("two_words", q, -1);
    do_reset();
    q = '{8'h00, 8'h00, 8'hAA};
    send_image(q, -1);
    verify("empty", q, -1);
    do_reset();
    q = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h01, 8'h00};
    send_image(q, 2);
    verify("frame_err", q, 2);
    do_reset();
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(20);
    chk("glitch_quiet", {bus_a.done, bus_a.frame_err, 32'(wa.size())}, 34'd0);
    q = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_image(q, -1);
    verify("after_glitch", q, -1);
    do_reset();
    q = {8'h05, 8'h00};
    for (int i = 0; i < 20; i++) q.push_back(8'($urandom));
    send_image(q[0:6], -1);
    rx = 1'b0;
    tick(30);
    do_reset();
    check_reset("mid_reset");
    send_image(q, -1);
    verify("overflow", q, -1);
    for (int r = 0; r < 10; r++) begin
      n = $urandom_range(0, 5);
      q = {8'(n), 8'h00};
      for (int i = 0; i < 4 * n + int'($urandom_range(0, 2)); i++) q.push_back(8'($urandom));
      bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, q.size() - 1)) : -1;
      do_reset();
      send_image(q, bad);
      verify("random", q, bad);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
